// File: rtl/flow_learn_ctrl.sv
// Arbitrates the flow table's single write port between host AXI-Lite writes
// and the hardware flow-learning engine (five-word entry writes, round-robin allocation).
module flow_learn_ctrl #(
    parameter int NUM_ENTRIES = 32,
    parameter int TIMEOUT     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_learn_en,
    input  logic         i_host_we,
    input  logic [7:0]   i_host_waddr,
    input  logic [31:0]  i_host_wdata,
    output logic         o_host_wdone,
    input  logic         i_miss_valid,
    input  logic [127:0] i_miss_key,
    output logic         o_miss_ready,
    output logic         o_ft_we,
    output logic [7:0]   o_ft_waddr,
    output logic [31:0]  o_ft_wdata,
    input  logic         i_ft_wdone,
    output logic         o_busy,
    output logic [4:0]   o_next_entry,
    output logic [15:0]  o_learn_count,
    output logic         o_timeout_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HOST_WR   = 3'd1;
    localparam logic [2:0] S_HOST_WAIT = 3'd2;
    localparam logic [2:0] S_LRN_WR    = 3'd3;
    localparam logic [2:0] S_LRN_WAIT  = 3'd4;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]   r_state;
    logic         r_host_pend;
    logic [7:0]   r_host_addr;
    logic [31:0]  r_host_data;
    logic         r_lrn_pend;
    logic [127:0] r_key;
    logic [127:0] r_last_key;
    logic         r_last_key_vld;
    logic [2:0]   r_word;
    logic [TW-1:0] r_tmo;
    logic [4:0]   r_next_entry;
    logic [15:0]  r_learn_count;
    logic         r_timeout_err;
    logic         r_host_wdone;

    logic w_host_acc;
    logic w_miss_hs;
    logic w_miss_dup;
    logic w_lrn_acc;
    logic w_host_req;
    logic w_lrn_req;
    logic w_in_wait;
    logic w_tmo;
    logic w_wait_done;
    logic w_lrn_last;

    assign o_miss_ready = rst_n && i_learn_en && !r_lrn_pend;

    // Requests seen in the capture cycle count immediately so an idle bus issues ft_we next cycle.
    assign w_host_acc  = i_host_we && !r_host_pend;
    assign w_miss_hs   = i_miss_valid && o_miss_ready;
    assign w_miss_dup  = r_last_key_vld && (i_miss_key == r_last_key);
    assign w_lrn_acc   = w_miss_hs && !w_miss_dup;
    assign w_host_req  = r_host_pend || w_host_acc;
    assign w_lrn_req   = r_lrn_pend || w_lrn_acc;
    assign w_in_wait   = (r_state == S_HOST_WAIT) || (r_state == S_LRN_WAIT);
    assign w_tmo       = (r_tmo == TW'(TIMEOUT - 1));
    assign w_wait_done = i_ft_wdone || w_tmo;
    assign w_lrn_last  = (r_state == S_LRN_WAIT) && w_wait_done && (r_word == 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_host_pend <= 1'b0;
            r_host_addr <= '0;
            r_host_data <= '0;
        end else if (w_host_acc) begin
            r_host_pend <= 1'b1;
            r_host_addr <= i_host_waddr;
            r_host_data <= i_host_wdata;
        end else if ((r_state == S_HOST_WAIT) && w_wait_done) begin
            r_host_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lrn_pend <= 1'b0;
            r_key      <= '0;
        end else if (w_lrn_acc) begin
            r_lrn_pend <= 1'b1;
            r_key      <= i_miss_key;
        end else if (w_lrn_last) begin
            r_lrn_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_word  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_host_req) begin
                        r_state <= S_HOST_WR;
                    end else if (w_lrn_req) begin
                        r_state <= S_LRN_WR;
                        r_word  <= 3'd0;
                    end
                end
                S_HOST_WR: r_state <= S_HOST_WAIT;
                S_HOST_WAIT: begin
                    if (w_wait_done) r_state <= S_IDLE;
                end
                S_LRN_WR: r_state <= S_LRN_WAIT;
                S_LRN_WAIT: begin
                    if (w_wait_done) begin
                        if (r_word == 3'd4) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_word  <= r_word + 3'd1;
                            r_state <= S_LRN_WR;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Timeout counter restarts every time a wait state is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo         <= '0;
            r_timeout_err <= 1'b0;
            r_host_wdone  <= 1'b0;
        end else begin
            r_host_wdone <= (r_state == S_HOST_WAIT) && w_wait_done;
            if (w_in_wait && !w_wait_done) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= '0;
            end
            if (w_in_wait && !i_ft_wdone && w_tmo) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_entry   <= '0;
            r_learn_count  <= '0;
            r_last_key     <= '0;
            r_last_key_vld <= 1'b0;
        end else if (w_lrn_last) begin
            r_last_key     <= r_key;
            r_last_key_vld <= 1'b1;
            r_next_entry   <= (r_next_entry == 5'(NUM_ENTRIES - 1)) ? 5'd0 : r_next_entry + 5'd1;
            if (r_learn_count != 16'hFFFF) begin
                r_learn_count <= r_learn_count + 16'd1;
            end
        end
    end

    // The valid/flow_id word goes out last so a half-written entry never matches.
    always_comb begin
        o_ft_we    = 1'b0;
        o_ft_waddr = '0;
        o_ft_wdata = '0;
        case (r_state)
            S_HOST_WR: begin
                o_ft_we    = 1'b1;
                o_ft_waddr = r_host_addr;
                o_ft_wdata = r_host_data;
            end
            S_LRN_WR: begin
                o_ft_we    = 1'b1;
                o_ft_waddr = {r_next_entry, r_word};
                case (r_word)
                    3'd0:    o_ft_wdata = r_key[31:0];
                    3'd1:    o_ft_wdata = r_key[63:32];
                    3'd2:    o_ft_wdata = r_key[95:64];
                    3'd3:    o_ft_wdata = r_key[127:96];
                    default: o_ft_wdata = {15'b0, 1'b1, 11'b0, r_next_entry};
                endcase
            end
            default: ;
        endcase
    end

    assign o_host_wdone  = r_host_wdone;
    assign o_busy        = (r_state != S_IDLE) || r_host_pend || r_lrn_pend;
    assign o_next_entry  = r_next_entry;
    assign o_learn_count = r_learn_count;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: doc/flow_learn_ctrl.md
Name: flow_learn_ctrl

Overview:
Owns the flow table's single configuration write port and shares it between host AXI-Lite writes and a hardware flow-learning engine. On a flow-miss event it allocates the next table entry round-robin and sequences a five-word entry write. Sits between the AXI address decoder (host side) and flow_table (waddr/wdata/we/wdone port). Host writes are forwarded unmodified.

Parameters:
NUM_ENTRIES, 32, flow table entries; power of two, 2..32; each entry spans 8 word addresses.
TIMEOUT, 64, cycles to wait for ft_wdone before abandoning a write.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
learn_en  in  1  CSR enable for hardware learning
host_we  in  1  host write strobe, one cycle
host_waddr  in  8  host flow-table word address
host_wdata  in  32  host write data
host_wdone  out  1  host write complete, one-cycle pulse
miss_valid  in  1  flow-miss event valid
miss_key  in  128  flow key of the missed flow
miss_ready  out  1  miss accepted when miss_valid && miss_ready
ft_we  out  1  flow table write strobe, one cycle
ft_waddr  out  8  flow table word address
ft_wdata  out  32  flow table write data
ft_wdone  in  1  flow table write complete pulse
busy  out  1  any transaction pending or in flight
next_entry  out  5  next entry index to allocate
learn_count  out  16  entries learned, saturating
timeout_err  out  1  sticky; set on any ft_wdone timeout

Behaviour:
- Reset (async, rst_n low): FSM to IDLE. All outputs 0, except miss_ready, which is 0 while rst_n is low and then follows its equation. Pending registers, word counter, last-key register, last_key_vld and the timeout counter are cleared. An in-flight write is abandoned, and no wdone is produced for it.
- Host capture: host_we latches host_waddr and host_wdata into a one-deep pending register and sets host_pend. A host_we that arrives while host_pend is already set is ignored. The host protocol forbids this case.
- Miss capture: miss_ready = learn_en && !lrn_pend. On a handshake, latch miss_key and set lrn_pend. When learn_en is 0 the block still accepts host writes normally.
- Dedup: if the accepted miss_key equals the last learned key and last_key_vld is set, drop it. lrn_pend stays 0.
- FSM states: IDLE, HOST_WR, HOST_WAIT, LRN_WR, LRN_WAIT.
- IDLE: if host_pend, go to HOST_WR. Otherwise, if lrn_pend, go to LRN_WR with word=0. When both are pending in the same cycle, host wins.
- HOST_WR: for one cycle, ft_we=1, ft_waddr=host addr, ft_wdata=host data. Then go to HOST_WAIT.
- HOST_WAIT: on ft_wdone, clear host_pend, pulse host_wdone in the next cycle, and go to IDLE.
- LRN_WR: for one cycle, ft_we=1 and ft_waddr={entry, word[2:0]}, with entry zero-extended into the upper 5 bits.
  - Words 0-3 carry ft_wdata = miss_key[32w+31:32w].
  - Word 4 carries {15'b0, 1'b1 valid at bit 16, flow_id[15:0] = entry zero-extended}.
  - Then go to LRN_WAIT.
- LRN_WAIT: on ft_wdone, if word<4, increment word and go to LRN_WR. If word==4, finish the learn:
  - clear lrn_pend;
  - store the key as the last learned key and set last_key_vld;
  - next_entry = (next_entry+1) mod NUM_ENTRIES, wrapping from NUM_ENTRIES-1 to 0 and overwriting the oldest entry;
  - learn_count += 1, saturating at 16'hFFFF;
  - go to IDLE.
- Atomicity: a learn sequence is never pre-empted. Host writes wait at most 5 write transactions. The valid word is written last, so a partially written entry never matches.
- Timeout: the counter resets on entry to any WAIT state. If it reaches TIMEOUT without ft_wdone, set timeout_err and treat the write as complete (host_wdone still pulses; the learn sequence advances). timeout_err clears only on reset.
- ft_wdone is ignored outside the WAIT states.
- busy = (state != IDLE) || host_pend || lrn_pend.
- Latency: host_we at cycle t gives ft_we at t+1 when the bus is idle. host_wdone comes one cycle after ft_wdone.

Test Plan:
- Host write at idle: host_we, waddr=0x13, wdata=0xDEADBEEF at t; ft_wdone at t+3 -> ft_we at t+1 with the same addr/data; host_wdone at t+4; busy low by t+5.
- Learn: learn_en=1, miss_key=0x00112233_44556677_8899AABB_CCDDEEFF, ft_wdone one cycle after each ft_we -> five writes to 0x00..0x04 with data 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233, 0x00010000; next_entry=1; learn_count=1.
- Simultaneous: host_we and miss handshake in the same cycle -> host write goes first, then the 5-word learn. A host_we issued mid-learn is delayed until after word 4 completes.
- Dedup and wrap: NUM_ENTRIES=2; learn keys A, A, B, C -> the second A is dropped. C is written to entry 0 at addresses 0x00-0x04, and next_entry=1.
- Timeout: TIMEOUT=8, ft_wdone withheld on a host write -> host_wdone 9 cycles after ft_we, timeout_err=1 and sticky.
- Reset mid-learn: rst_n low during LRN_WAIT of word 2 -> all outputs 0 immediately. Once rst_n is high again, miss_ready=learn_en. The next miss writes entry 0 starting at word 0.
